// File: rtl/stepgen_pkg.sv
// Shared types and widths for the step/dir pulse generator.
package stepgen_pkg;

    localparam int CMD_W = 16;
    localparam int CFG_W = 8;

    localparam logic [CMD_W-1:0] CMD_ONE = {{(CMD_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DIR_SETUP  = 2'd1,
        ST_PULSE_HIGH = 2'd2,
        ST_PULSE_LOW  = 2'd3
    } state_e;

    // A zero config value would mean "no time at all"; treat it as one clock.
    function automatic logic [CFG_W-1:0] at_least_one(input logic [CFG_W-1:0] v);
        return (v == '0) ? {{(CFG_W-1){1'b0}}, 1'b1} : v;
    endfunction

endpackage

// File: rtl/step_dir_generator_if.sv
// Command, configuration and stepper-side signals of the step/dir generator.
interface step_dir_generator_if #(
    parameter int POS_W = 32
);
    import stepgen_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CMD_W-1:0] cmd_steps;
    logic [CMD_W-1:0] cmd_period;
    logic [CFG_W-1:0] config_pulse_width;
    logic [CFG_W-1:0] config_dir_setup;
    logic             abort;
    logic             step;
    logic             dir;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [POS_W-1:0] position;

    modport master (
        output cmd_valid, cmd_dir, cmd_steps, cmd_period,
               config_pulse_width, config_dir_setup, abort,
        input  cmd_ready, step, dir, busy, done, aborted, position
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_steps, cmd_period,
               config_pulse_width, config_dir_setup, abort,
        output cmd_ready, step, dir, busy, done, aborted, position
    );

endinterface

// File: rtl/step_interval_timer.sv
// Loadable down-counter; zero is high while the count sits at zero.
module step_interval_timer
    import stepgen_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CMD_W-1:0] load_value,
    output logic             zero
);

    logic [CMD_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CMD_ONE;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/step_dir_generator.sv
// Step/dir pulse generator: runs counted step moves with dir setup, pulse
// width and period control, abort handling and a signed position count.
module step_dir_generator
    import stepgen_pkg::*;
#(
    parameter int POS_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    step_dir_generator_if.slave  bus
);

    localparam logic [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

    state_e           state_q;
    logic             step_q;
    logic             dir_q;
    logic             done_q;
    logic             aborted_q;
    logic             abort_pend_q;
    logic [CFG_W-1:0] pw_q;
    logic [CMD_W-1:0] low_q;
    logic [CMD_W-1:0] steps_left_q;
    logic [POS_W-1:0] pos_q;

    logic [CFG_W-1:0] pw_cmd;
    logic [CFG_W-1:0] setup_cmd;
    logic [CMD_W-1:0] pw_cmd_w;
    logic [CMD_W-1:0] pw_q_w;
    logic [CMD_W-1:0] period_min;
    logic [CMD_W-1:0] period_cmd;
    logic [CMD_W-1:0] low_cmd;
    logic [POS_W-1:0] pos_next;
    logic             accept;
    logic             dir_change;
    logic             more_steps;
    logic             abort_stop;
    logic             timer_load;
    logic [CMD_W-1:0] timer_value;
    logic             timer_zero;

    assign pw_cmd     = at_least_one(bus.config_pulse_width);
    assign setup_cmd  = at_least_one(bus.config_dir_setup);
    assign pw_cmd_w   = {{(CMD_W-CFG_W){1'b0}}, pw_cmd};
    assign pw_q_w     = {{(CMD_W-CFG_W){1'b0}}, pw_q};
    // The period must leave at least one low clock after the high time.
    assign period_min = pw_cmd_w + CMD_ONE;
    assign period_cmd = (bus.cmd_period < period_min) ? period_min : bus.cmd_period;
    assign low_cmd    = period_cmd - pw_cmd_w;

    assign accept     = (state_q == ST_IDLE) && bus.cmd_valid && !bus.abort;
    assign dir_change = (bus.cmd_dir != dir_q);
    assign more_steps = (steps_left_q != '0);
    assign abort_stop = bus.abort || abort_pend_q;
    assign pos_next   = dir_q ? pos_q + POS_ONE : pos_q - POS_ONE;

    // Timer is loaded on the edge that enters a timed state, with length-1.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept && dir_change) begin
                    timer_load  = 1'b1;
                    timer_value = {{(CMD_W-CFG_W){1'b0}}, setup_cmd} - CMD_ONE;
                end else if (accept && (bus.cmd_steps != '0)) begin
                    timer_load  = 1'b1;
                    timer_value = pw_cmd_w - CMD_ONE;
                end
            end
            ST_DIR_SETUP, ST_PULSE_LOW: begin
                if (!bus.abort && timer_zero && more_steps) begin
                    timer_load  = 1'b1;
                    timer_value = pw_q_w - CMD_ONE;
                end
            end
            ST_PULSE_HIGH: begin
                if (timer_zero && !abort_stop) begin
                    timer_load  = 1'b1;
                    timer_value = low_q - CMD_ONE;
                end
            end
            default: ;
        endcase
    end

    step_interval_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            step_q       <= 1'b0;
            dir_q        <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            pw_q         <= '0;
            low_q        <= '0;
            steps_left_q <= '0;
            pos_q        <= '0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        pw_q  <= pw_cmd;
                        low_q <= low_cmd;
                        if (dir_change) begin
                            dir_q        <= bus.cmd_dir;
                            steps_left_q <= bus.cmd_steps;
                            state_q      <= ST_DIR_SETUP;
                        end else if (bus.cmd_steps != '0) begin
                            steps_left_q <= bus.cmd_steps - CMD_ONE;
                            step_q       <= 1'b1;
                            pos_q        <= pos_next;
                            state_q      <= ST_PULSE_HIGH;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_DIR_SETUP, ST_PULSE_LOW: begin
                    if (bus.abort) begin
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else if (timer_zero && more_steps) begin
                        steps_left_q <= steps_left_q - CMD_ONE;
                        step_q       <= 1'b1;
                        pos_q        <= pos_next;
                        state_q      <= ST_PULSE_HIGH;
                    end else if (timer_zero) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_PULSE_HIGH: begin
                    // An abort here is remembered so the pulse is never cut short.
                    if (bus.abort) begin
                        abort_pend_q <= 1'b1;
                    end
                    if (timer_zero) begin
                        step_q <= 1'b0;
                        if (abort_stop) begin
                            abort_pend_q <= 1'b0;
                            done_q       <= 1'b1;
                            aborted_q    <= 1'b1;
                            state_q      <= ST_IDLE;
                        end else begin
                            state_q <= ST_PULSE_LOW;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.step      = step_q;
    assign bus.dir       = dir_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
    assign bus.position  = pos_q;

endmodule

// File: tb/tb_step_dir_generator.sv
// Scoreboard bench for step_dir_generator: expected step rises and done
// pulses are queued at command time and checked as the DUT produces them.
module tb_step_dir_generator;

    typedef struct {
        int          cyc;
        logic [31:0] pos;
        logic        dir;
        int          hi;
    } rise_t;

    typedef struct {
        int   cyc;
        logic ab;
    } done_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    step_dir_generator_if #(.POS_W(32)) bus ();

    step_dir_generator #(.POS_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    rise_t exp_rise[$];
    done_t exp_done[$];

    int          cyc;
    int          n_chk;
    int          n_fail;
    int          hi_start;
    int          hi_exp;
    int          last_rise;
    logic        prev_step;
    logic        hi_pending;
    logic        saw_done;
    logic        m_dir;
    logic [31:0] m_pos;

    task automatic tick();
        rise_t er;
        done_t ed;
        @(posedge clk);
        cyc++;
        #1;
        if (bus.step && !prev_step) begin
            n_chk++;
            last_rise = cyc;
            if (exp_rise.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_step at cyc %0d, required no step", cyc);
            end else begin
                er = exp_rise.pop_front();
                if (cyc !== er.cyc || bus.position !== er.pos || bus.dir !== er.dir) begin
                    n_fail++;
                    $display("FAIL step_rise got cyc=%0d pos=%h dir=%b, required cyc=%0d pos=%h dir=%b",
                             cyc, bus.position, bus.dir, er.cyc, er.pos, er.dir);
                end
                hi_exp     = er.hi;
                hi_start   = cyc;
                hi_pending = 1'b1;
            end
        end
        if (!bus.step && prev_step && hi_pending) begin
            n_chk++;
            hi_pending = 1'b0;
            if ((cyc - hi_start) !== hi_exp) begin
                n_fail++;
                $display("FAIL step_high_time got %0d, required %0d", cyc - hi_start, hi_exp);
            end
        end
        if (bus.done) begin
            n_chk++;
            saw_done = 1'b1;
            if (exp_done.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done at cyc %0d, required none", cyc);
            end else begin
                ed = exp_done.pop_front();
                if (cyc !== ed.cyc || bus.aborted !== ed.ab) begin
                    n_fail++;
                    $display("FAIL done_pulse got cyc=%0d aborted=%b, required cyc=%0d aborted=%b",
                             cyc, bus.aborted, ed.cyc, ed.ab);
                end
            end
        end
        prev_step = bus.step;
    endtask

    // Drives one command and queues its expected rises and done pulse.
    // Returns with cyc = t+1, the first cycle after acceptance.
    task automatic issue(input logic d, input int steps, input int period,
                         input int pw, input int ds, output int t);
        int    n = 0;
        int    pwe, se, p, first, dc;
        logic  chg;
        rise_t r;
        done_t e;
        while (!bus.cmd_ready && n < 300) begin
            tick();
            n++;
        end
        if (!bus.cmd_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL cmd_ready_timeout got 0, required 1");
        end
        bus.cmd_dir            = d;
        bus.cmd_steps          = 16'(steps);
        bus.cmd_period         = 16'(period);
        bus.config_pulse_width = 8'(pw);
        bus.config_dir_setup   = 8'(ds);
        bus.cmd_valid          = 1'b1;
        t     = cyc;
        pwe   = (pw == 0) ? 1 : pw;
        se    = (ds == 0) ? 1 : ds;
        p     = (period < pwe + 1) ? pwe + 1 : period;
        chg   = (d != m_dir);
        first = chg ? t + 1 + se : t + 1;
        m_dir = d;
        for (int i = 0; i < steps; i++) begin
            m_pos  = d ? m_pos + 32'd1 : m_pos - 32'd1;
            r.cyc  = first + i * p;
            r.pos  = m_pos;
            r.dir  = d;
            r.hi   = pwe;
            exp_rise.push_back(r);
        end
        dc    = (steps == 0) ? first : first + steps * p;
        e.cyc = dc;
        e.ab  = 1'b0;
        exp_done.push_back(e);
        saw_done = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!saw_done && n < budget) begin
            tick();
            n++;
        end
        n_chk++;
        if (!saw_done) begin
            n_fail++;
            $display("FAIL done_timeout got no done in %0d cycles, required done", budget);
        end
    endtask

    task automatic test_reset();
        #2;
        n_chk++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.step !== 1'b0 ||
            bus.dir !== 1'b0 || bus.done !== 1'b0 || bus.aborted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got rdy=%b busy=%b step=%b dir=%b done=%b ab=%b, required 1 0 0 0 0 0",
                     bus.cmd_ready, bus.busy, bus.step, bus.dir, bus.done, bus.aborted);
        end
        n_chk++;
        if (bus.position !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_position got %h, required 0", bus.position);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_dir_change();
        int t;
        issue(1'b1, 2, 8, 3, 5, t);
        n_chk++;
        if (bus.dir !== 1'b1 || bus.step !== 1'b0 || bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL dir_change_t1 got dir=%b step=%b busy=%b rdy=%b, required 1 0 1 0",
                     bus.dir, bus.step, bus.busy, bus.cmd_ready);
        end
        wait_done(200);
    endtask

    task automatic test_basic();
        int          t;
        logic [31:0] p0;
        p0 = m_pos;
        issue(1'b1, 3, 10, 4, 7, t);
        wait_done(200);
        n_chk++;
        if (bus.position !== p0 + 32'd3) begin
            n_fail++;
            $display("FAIL basic_position got %h, required %h", bus.position, p0 + 32'd3);
        end
    endtask

    task automatic test_min_period();
        int t;
        issue(1'b1, 4, 2, 4, 0, t);
        wait_done(200);
    endtask

    task automatic test_config_hold();
        int t;
        issue(1'b1, 3, 6, 2, 1, t);
        bus.config_pulse_width = 8'd9;
        bus.config_dir_setup   = 8'd9;
        wait_done(200);
    endtask

    task automatic test_zero_steps();
        int          t;
        logic [31:0] p0;
        p0 = m_pos;
        issue(1'b0, 0, 10, 2, 3, t);
        wait_done(50);
        n_chk++;
        if (bus.position !== p0 || bus.dir !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_steps got pos=%h dir=%b, required pos=%h dir=0", bus.position, bus.dir, p0);
        end
        issue(1'b0, 0, 10, 2, 3, t);
        wait_done(10);
    endtask

    task automatic test_zero_config();
        int t;
        issue(1'b1, 2, 0, 0, 0, t);
        wait_done(50);
    endtask

    task automatic test_abort_high();
        int          t;
        logic [31:0] p0;
        done_t       e;
        p0 = m_pos;
        issue(1'b1, 5, 20, 6, 0, t);
        tick();
        bus.abort = 1'b1;
        exp_rise.delete();
        exp_done.delete();
        e.cyc = t + 7;
        e.ab  = 1'b1;
        exp_done.push_back(e);
        m_pos = p0 + 32'd1;
        tick();
        bus.abort = 1'b0;
        wait_done(50);
        repeat (25) tick();
        n_chk++;
        if (bus.position !== m_pos || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_high_end got pos=%h busy=%b, required pos=%h busy=0", bus.position, bus.busy, m_pos);
        end
    endtask

    task automatic test_abort_low();
        int          t;
        logic [31:0] p0;
        done_t       e;
        p0 = m_pos;
        issue(1'b1, 3, 10, 2, 0, t);
        repeat (3) tick();
        bus.abort = 1'b1;
        exp_rise.delete();
        exp_done.delete();
        e.cyc = t + 5;
        e.ab  = 1'b1;
        exp_done.push_back(e);
        m_pos = p0 + 32'd1;
        tick();
        bus.abort = 1'b0;
        wait_done(20);
        repeat (15) tick();
        n_chk++;
        if (bus.position !== m_pos) begin
            n_fail++;
            $display("FAIL abort_low_position got %h, required %h", bus.position, m_pos);
        end
    endtask

    task automatic test_abort_setup();
        int          t;
        logic [31:0] p0;
        logic        nd;
        done_t       e;
        p0 = m_pos;
        nd = ~m_dir;
        issue(nd, 2, 5, 2, 8, t);
        repeat (2) tick();
        bus.abort = 1'b1;
        exp_rise.delete();
        exp_done.delete();
        e.cyc = t + 4;
        e.ab  = 1'b1;
        exp_done.push_back(e);
        m_pos = p0;
        tick();
        bus.abort = 1'b0;
        wait_done(20);
        repeat (15) tick();
        n_chk++;
        if (bus.dir !== nd || bus.position !== p0) begin
            n_fail++;
            $display("FAIL abort_setup_end got dir=%b pos=%h, required dir=%b pos=%h", bus.dir, bus.position, nd, p0);
        end
    endtask

    task automatic test_abort_priority();
        bus.cmd_dir            = ~m_dir;
        bus.cmd_steps          = 16'd2;
        bus.cmd_period         = 16'd4;
        bus.config_pulse_width = 8'd1;
        bus.config_dir_setup   = 8'd1;
        bus.cmd_valid          = 1'b1;
        bus.abort              = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        bus.abort     = 1'b0;
        n_chk++;
        if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.dir !== m_dir) begin
            n_fail++;
            $display("FAIL abort_priority got busy=%b rdy=%b dir=%b, required 0 1 %b",
                     bus.busy, bus.cmd_ready, bus.dir, m_dir);
        end
        repeat (10) tick();
        n_chk++;
        if (bus.position !== m_pos) begin
            n_fail++;
            $display("FAIL abort_priority_position got %h, required %h", bus.position, m_pos);
        end
    endtask

    task automatic test_back_to_back();
        int t, la;
        issue(1'b1, 2, 7, 3, 0, t);
        wait_done(100);
        la = last_rise;
        issue(1'b1, 2, 7, 3, 0, t);
        n_chk++;
        if ((last_rise - la) < 7) begin
            n_fail++;
            $display("FAIL back_to_back_spacing got %0d, required >= 7", last_rise - la);
        end
        wait_done(100);
    endtask

    task automatic test_wrap();
        int t;
        dut.pos_q = 32'h7FFF_FFFF;
        m_pos     = 32'h7FFF_FFFF;
        issue(1'b1, 1, 3, 1, 0, t);
        wait_done(50);
        n_chk++;
        if (bus.position !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL wrap_position got %h, required 80000000", bus.position);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        issue(1'b1, 3, 10, 6, 0, t);
        tick();
        reset = 1'b1;
        #1;
        n_chk++;
        if (bus.step !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0 ||
            bus.cmd_ready !== 1'b1 || bus.dir !== 1'b0 || bus.position !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid got step=%b done=%b busy=%b rdy=%b dir=%b pos=%h, required 0 0 0 1 0 0",
                     bus.step, bus.done, bus.busy, bus.cmd_ready, bus.dir, bus.position);
        end
        exp_rise.delete();
        exp_done.delete();
        hi_pending = 1'b0;
        prev_step  = 1'b0;
        m_pos      = 32'd0;
        m_dir      = 1'b0;
        saw_done   = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (20) tick();
        n_chk++;
        if (saw_done !== 1'b0 || bus.step !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done got done_seen=%b step=%b, required 0 0", saw_done, bus.step);
        end
    endtask

    initial begin
        reset                  = 1'b1;
        bus.cmd_valid          = 1'b0;
        bus.cmd_dir            = 1'b0;
        bus.cmd_steps          = '0;
        bus.cmd_period         = '0;
        bus.config_pulse_width = '0;
        bus.config_dir_setup   = '0;
        bus.abort              = 1'b0;
        cyc        = 0;
        n_chk      = 0;
        n_fail     = 0;
        hi_start   = 0;
        hi_exp     = 0;
        last_rise  = 0;
        prev_step  = 1'b0;
        hi_pending = 1'b0;
        saw_done   = 1'b0;
        m_dir      = 1'b0;
        m_pos      = 32'd0;

        test_reset();
        test_dir_change();
        test_basic();
        test_min_period();
        test_config_hold();
        test_zero_steps();
        test_zero_config();
        test_abort_high();
        test_abort_low();
        test_abort_setup();
        test_abort_priority();
        test_back_to_back();
        test_wrap();
        test_reset_mid();

        n_chk++;
        if (exp_rise.size() != 0 || exp_done.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expected got rises=%0d dones=%0d, required 0 0", exp_rise.size(), exp_done.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
